// File: rtl/agc_ctrl.sv
// ---------------------------------------------------------------------------
// agc_ctrl -- automatic gain control loop controller
//
// Watches the signed output of a gain multiplier, measures the peak magnitude
// over a fixed window of accepted samples, and then nudges the unsigned gain
// word fed back to the multiplier:
//   peak above TGT_HI -> halve the gain (fast attack)
//   peak below TGT_LO -> gain + 1      (slow release)
//   otherwise         -> hold
// The gain is always kept inside [GAIN_MIN, GAIN_MAX].
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst        : asynchronous, active-high reset
//   en         : enables measurement and adjustment
//   valid_i    : data_i carries a sample this cycle
//   data_i     : signed two's-complement sample (multiplier output), N bits
//   amplify_o  : unsigned gain word driven into the multiplier, N bits
//   update_o   : one-cycle pulse when a gain decision completes
//   peak_o     : unsigned peak magnitude of the last completed window, N bits
// ---------------------------------------------------------------------------
module agc_ctrl #(
    parameter int unsigned    N         = 32,
    parameter int unsigned    WIN_LOG2  = 8,
    parameter logic [N-1:0]   GAIN_INIT = N'(16),
    parameter logic [N-1:0]   GAIN_MIN  = N'(1),
    parameter logic [N-1:0]   GAIN_MAX  = N'(255),
    parameter logic [N-1:0]   TGT_HI    = N'(1) << (N - 3),
    parameter logic [N-1:0]   TGT_LO    = N'(1) << (N - 5)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         valid_i,
    input  logic [N-1:0] data_i,
    output logic [N-1:0] amplify_o,
    output logic         update_o,
    output logic [N-1:0] peak_o
);

    // One extra bit so the counter can hold the full window size without
    // wrapping; it is cleared in ADJUST before it could ever overflow.
    localparam int unsigned         CNT_W    = WIN_LOG2 + 1;
    localparam logic [CNT_W-1:0]    WIN_LAST = CNT_W'((1 << WIN_LOG2) - 1);

    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MOST_POS = {1'b0, {(N-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        ADJUST  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] sample_cnt;
    logic [N-1:0]     run_peak;

    logic [N-1:0]     mag;
    logic [N-1:0]     peak_next;
    logic [N-1:0]     gain_halved;
    logic [N-1:0]     gain_next;

    // -----------------------------------------------------------------------
    // Sample magnitude and running-peak candidate.
    // The most-negative input has no positive counterpart in N bits, so it
    // saturates to the largest positive magnitude instead of wrapping.
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block; a path that leaves it unassigned would infer a latch.
    always_comb begin
        mag = data_i;
        if (data_i[N-1]) begin
            if (data_i == MOST_NEG) begin
                mag = MOST_POS;
            end else begin
                mag = -data_i;
            end
        end
        peak_next = (mag > run_peak) ? mag : run_peak;
    end

    // -----------------------------------------------------------------------
    // Gain decision for the window peak held in run_peak.
    // The increment path compares against GAIN_MAX before adding so that a
    // GAIN_MAX at the top of the N-bit range cannot wrap to zero.
    // -----------------------------------------------------------------------
    always_comb begin
        gain_halved = amplify_o >> 1;
        gain_next   = amplify_o;
        if (run_peak > TGT_HI) begin
            gain_next = (gain_halved < GAIN_MIN) ? GAIN_MIN : gain_halved;
        end else if (run_peak < TGT_LO) begin
            gain_next = (amplify_o >= GAIN_MAX) ? GAIN_MAX : amplify_o + N'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs.
    // -----------------------------------------------------------------------
    // NOTE: every register here is a flop with a known reset value; there is
    // no memory array, so nothing is left unreset.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            amplify_o  <= GAIN_INIT;
            update_o   <= 1'b0;
            peak_o     <= '0;
            sample_cnt <= '0;
            run_peak   <= '0;
        end else begin
            // update_o is a single-cycle strobe; only ADJUST raises it.
            update_o <= 1'b0;

            case (state)
                IDLE: begin
                    // valid_i is ignored here; a window starts on entry to
                    // MEASURE with a clean count and peak.
                    if (en) begin
                        state      <= MEASURE;
                        sample_cnt <= '0;
                        run_peak   <= '0;
                    end
                end

                MEASURE: begin
                    if (!en) begin
                        // Abandon the partial window; gain and reported peak
                        // keep their last values.
                        state      <= IDLE;
                        sample_cnt <= '0;
                        run_peak   <= '0;
                    end else if (valid_i) begin
                        run_peak   <= peak_next;
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        // The last sample of the window is folded into the
                        // peak on the same edge that moves to ADJUST.
                        if (sample_cnt == WIN_LAST) begin
                            state <= ADJUST;
                        end
                    end
                end

                ADJUST: begin
                    // Runs unconditionally once entered; valid_i is dropped
                    // this cycle and en only picks the following state.
                    amplify_o  <= gain_next;
                    peak_o     <= run_peak;
                    update_o   <= 1'b1;
                    sample_cnt <= '0;
                    run_peak   <= '0;
                    state      <= en ? MEASURE : IDLE;
                end

                default: begin
                    state      <= IDLE;
                    sample_cnt <= '0;
                    run_peak   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_agc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_agc_ctrl -- self-checking bench for agc_ctrl
//
// Directed scenarios (reset, attack/release, negative and saturated input,
// clamps, disable, dropped sample, mid-window reset, gaps) followed by a
// randomized phase. A behavioural model keeps the accepted window as a queue
// of magnitudes and applies the gain rule with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_agc_ctrl;

    localparam int N = 32;

    logic          clk;
    logic          rst;
    logic          en;
    logic          valid_i;
    logic [N-1:0]  data_i;
    logic [N-1:0]  amplify_o;
    logic          update_o;
    logic [N-1:0]  peak_o;

    int checks   = 0;
    int failures = 0;

    agc_ctrl #(
        .N         (32),
        .WIN_LOG2  (2),
        .GAIN_INIT (32'd16),
        .GAIN_MIN  (32'd1),
        .GAIN_MAX  (32'd255),
        .TGT_HI    (32'd1000),
        .TGT_LO    (32'd250)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .amplify_o (amplify_o),
        .update_o  (update_o),
        .peak_o    (peak_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, need finish)");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    localparam int WIN = 4;

    longint unsigned m_gain;
    longint unsigned m_peak;
    bit              m_update;
    bit              m_running;   // window collection enabled
    bit              m_full;      // window complete, decision due next edge
    longint unsigned m_win[$];

    function automatic longint unsigned mag_of(input logic [31:0] d);
        longint s;
        s = longint'($signed(d));
        if (s == -64'sd2147483648) return 64'd2147483647;
        if (s < 0) return longint'(-s);
        return longint'(s);
    endfunction

    task automatic model_reset();
        m_gain    = 16;
        m_peak    = 0;
        m_update  = 0;
        m_running = 0;
        m_full    = 0;
        m_win.delete();
    endtask

    task automatic model_edge(input bit e, input bit v, input logic [31:0] d);
        longint unsigned pk;
        m_update = 0;
        if (m_full) begin
            pk = 0;
            foreach (m_win[i]) if (m_win[i] > pk) pk = m_win[i];
            if (pk > 1000) begin
                m_gain = m_gain / 2;
                if (m_gain < 1) m_gain = 1;
            end else if (pk < 250) begin
                m_gain = m_gain + 1;
                if (m_gain > 255) m_gain = 255;
            end
            m_peak    = pk;
            m_update  = 1;
            m_full    = 0;
            m_win.delete();
            m_running = e;
        end else if (!m_running) begin
            if (e) begin
                m_running = 1;
                m_win.delete();
            end
        end else if (!e) begin
            m_running = 0;
            m_win.delete();
        end else if (v) begin
            m_win.push_back(mag_of(d));
            if (m_win.size() == WIN) m_full = 1;
        end
    endtask

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".amplify"}, amplify_o, 32'(m_gain));
        check({tag, ".update"},  {31'd0, update_o}, {31'd0, m_update});
        check({tag, ".peak"},    peak_o, 32'(m_peak));
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic step(input bit e, input bit v, input logic [31:0] d);
        en      = e;
        valid_i = v;
        data_i  = d;
        @(posedge clk);
        #1;
        model_edge(e, v, d);
        check_model("step");
    endtask

    // Called 1 unit after an edge: assert rst between edges, check outputs
    // immediately, then release before the next edge.
    task automatic apply_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_async.amplify", amplify_o, 32'd16);
        check("rst_async.update",  {31'd0, update_o}, 32'd0);
        check("rst_async.peak",    peak_o, 32'd0);
        #2;
        rst = 1'b0;
    endtask

    // Four samples (optionally with random idle gaps) plus the decision edge.
    task automatic window(input logic [31:0] s [4], input int max_gap);
        for (int i = 0; i < 4; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int k = 0; k < g; k++) step(1'b1, 1'b0, 32'd0);
            step(1'b1, 1'b1, s[i]);
            check("win.no_early_pulse", {31'd0, update_o}, 32'd0);
        end
        step(1'b1, 1'b0, 32'd0);
        check("win.pulse", {31'd0, update_o}, 32'd1);
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 7))
            0: return 32'($urandom_range(0, 249));
            1: return 32'($urandom_range(250, 1000));
            2: return 32'($urandom_range(1001, 100000));
            3: return 32'h8000_0000;
            4: return 32'($urandom);
            5: return -32'($urandom_range(0, 2000));
            6: begin
                logic [31:0] edges [4];
                edges = '{32'd249, 32'd250, 32'd1000, 32'd1001};
                return edges[$urandom_range(0, 3)];
            end
            default: return 32'd0;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        logic [31:0] w [4];

        rst     = 1'b1;
        en      = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        model_reset();
        #2;
        check("por.amplify", amplify_o, 32'd16);
        check("por.update",  {31'd0, update_o}, 32'd0);
        check("por.peak",    peak_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Valid in IDLE with en low is ignored.
        step(1'b0, 1'b1, 32'd5000);
        step(1'b0, 1'b1, 32'd5000);

        // Attack and release.
        step(1'b1, 1'b0, 32'd0);                 // IDLE -> MEASURE
        w = '{32'd2000, 32'd10, -32'd5, 32'd7};
        window(w, 0);
        check("attack.amplify", amplify_o, 32'd8);
        check("attack.peak",    peak_o, 32'd2000);
        step(1'b1, 1'b0, 32'd0);
        check("attack.pulse_one_cycle", {31'd0, update_o}, 32'd0);
        w = '{32'd100, 32'd100, 32'd100, 32'd100};
        window(w, 0);
        check("release.amplify", amplify_o, 32'd9);
        check("release.peak",    peak_o, 32'd100);

        // Asynchronous reset with non-reset outputs present.
        apply_reset();
        step(1'b1, 1'b0, 32'd0);

        // Negative and saturated input.
        w = '{-32'd3000, 32'd0, 32'd0, 32'd0};
        window(w, 0);
        check("neg.peak",    peak_o, 32'd3000);
        check("neg.amplify", amplify_o, 32'd8);
        w = '{32'h8000_0000, 32'd0, 32'd0, 32'd0};
        window(w, 0);
        check("sat.peak",    peak_o, 32'h7FFF_FFFF);
        check("sat.amplify", amplify_o, 32'd4);

        // Climb to the upper clamp, then hold there.
        w = '{32'd10, 32'd10, 32'd10, 32'd10};
        for (int i = 0; i < 300 && m_gain < 255; i++) window(w, 0);
        check("clamp_hi.reached", amplify_o, 32'd255);
        window(w, 0);
        check("clamp_hi.amplify", amplify_o, 32'd255);

        // Fall to the lower clamp, then hold there.
        w = '{32'd5000, 32'd5000, 32'd5000, 32'd5000};
        for (int i = 0; i < 10 && m_gain > 1; i++) window(w, 0);
        check("clamp_lo.reached", amplify_o, 32'd1);
        window(w, 0);
        check("clamp_lo.amplify", amplify_o, 32'd1);

        // Disable after two samples: no pulse, gain held.
        step(1'b1, 1'b1, 32'd10);
        step(1'b1, 1'b1, 32'd10);
        step(1'b0, 1'b1, 32'd10);                // MEASURE -> IDLE
        step(1'b0, 1'b0, 32'd0);
        check("disable.update",  {31'd0, update_o}, 32'd0);
        check("disable.amplify", amplify_o, 32'd1);
        step(1'b1, 1'b0, 32'd0);                 // re-enter MEASURE
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'd10);
        step(1'b1, 1'b0, 32'd0);
        check("reenable.no_pulse_after_3", {31'd0, update_o}, 32'd0);
        step(1'b1, 1'b1, 32'd10);                // 4th fresh sample
        // Sample offered during ADJUST must be dropped.
        step(1'b1, 1'b1, 32'd9000);
        check("reenable.pulse",   {31'd0, update_o}, 32'd1);
        check("reenable.amplify", amplify_o, 32'd2);
        // Three more samples alone must not complete a window.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'd10);
        step(1'b1, 1'b0, 32'd0);
        check("dropped.no_pulse", {31'd0, update_o}, 32'd0);
        step(1'b1, 1'b1, 32'd10);
        step(1'b1, 1'b0, 32'd0);
        check("dropped.pulse",   {31'd0, update_o}, 32'd1);
        check("dropped.peak",    peak_o, 32'd10);
        check("dropped.amplify", amplify_o, 32'd3);

        // en low during ADJUST: decision still completes, then IDLE.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'd20);
        step(1'b0, 1'b0, 32'd0);
        check("en_off_adjust.pulse",   {31'd0, update_o}, 32'd1);
        check("en_off_adjust.amplify", amplify_o, 32'd4);

        // Mid-window reset.
        step(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'd5000);
        apply_reset();
        step(1'b1, 1'b1, 32'd5000);              // IDLE -> MEASURE, sample ignored
        check("midrst.update",  {31'd0, update_o}, 32'd0);
        check("midrst.amplify", amplify_o, 32'd16);

        // Same window back-to-back and with gaps.
        w = '{32'd400, -32'd300, 32'd800, 32'd600};
        window(w, 0);
        check("nogap.peak",    peak_o, 32'd800);
        check("nogap.amplify", amplify_o, 32'd16);
        window(w, 5);
        check("gap.peak",    peak_o, 32'd800);
        check("gap.amplify", amplify_o, 32'd16);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                apply_reset();
            end else begin
                step(r > 6, 1'($urandom_range(0, 1)), rand_data());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
